btn_cmd_sched: RTL and testbench
================================

# btn_cmd_sched

Command scheduler between the two-button debouncer and the game-state logic. Captures the single-cycle debounced pulses from `btn1_deb`/`btn2_deb` as direction commands in a small FIFO. Releases them to the game logic over a valid/ready handshake, rate-limited to a fixed number of commands per video frame so paddle/object motion stays frame-synchronous. Runs entirely in the `vgaclk` domain.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, 2..16.
- `MAX_PER_FRAME`, 1, commands that may be released per frame; 1..7.

Ports:
- `vgaclk`  in  1  clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high; every register clears on a rising edge where `reset`=1.
- `btn1_deb`  in  1  one-cycle pulse, command dir=0 (left).
- `btn2_deb`  in  1  one-cycle pulse, command dir=1 (right).
- `frame_tick`  in  1  one-cycle pulse at the start of vertical blank.
- `cmd_ready`  in  1  consumer can accept a command.
- `cmd_valid`  out  1  command presented; registered.
- `cmd_dir`  out  1  direction of the presented command; registered.
- `fifo_level`  out  $clog2(DEPTH)+1  entries held, including the presented one.
- `overflow`  out  1  one-cycle pulse when a command is dropped.
- `drop_cnt`  out  8  saturating count of dropped commands.

## Operation
- Reset values: `cmd_valid`=0, `cmd_dir`=0, `fifo_level`=0, `overflow`=0, `drop_cnt`=0, credits=0, state=WAIT.
- Capture: a cycle with exactly one of `btn1_deb`/`btn2_deb` high pushes that direction.
  - Both high: nothing is pushed; this is not counted as a drop.
- Full: a push while `fifo_level`==DEPTH is dropped. `overflow` pulses for 1 cycle and `drop_cnt` increments, saturating at 255.
  - A push and a pop on the same edge when full is accepted: the level stays DEPTH and there is no drop.
- Credits: 3-bit counter, reloaded to MAX_PER_FRAME on every `frame_tick`. A reload replaces the current value; unused credits do not accumulate.
- FSM:
  - WAIT: go to PRESENT when the FIFO is non-empty and credits>0. On that edge, `cmd_valid`←1 and `cmd_dir`←head entry.
  - PRESENT: `cmd_valid` and `cmd_dir` hold stable until the handshake (`cmd_valid`&&`cmd_ready`). On the handshake edge: pop the head, decrement credits, `cmd_valid`←0, return to WAIT.
  - A `frame_tick` during PRESENT reloads credits only; the presented command is unaffected.
  - Same-edge `frame_tick` and handshake: credits become MAX_PER_FRAME−1.
- Pointers wrap modulo DEPTH. The level arithmetic handles simultaneous push and pop (level unchanged).
- Reset asserted mid-handshake or mid-frame: everything clears. The presented command is lost, with no pop side effect.

## Timing
- Pulse sampled at edge k gives `fifo_level`=1 after edge k. With credits>0, `cmd_valid`=1 after edge k+1 (2-edge latency).
- Handshake at edge m gives `cmd_valid`=0 after edge m. The next `cmd_valid` comes no earlier than after edge m+1, so peak throughput is 1 command per 2 cycles.
- `overflow` is high only in the cycle after the dropping edge.
- `frame_tick` at edge f makes credits visible to the FSM from edge f+1.

## Configuration
- `BTN_CMD_COALESCE_EN` defined: a push whose direction is opposite to the tail entry removes that tail entry instead of being stored (left+right cancel). `fifo_level` decreases by 1, credits are unaffected, and the result is not a drop.
  - Coalescing applies only when the tail is not the entry currently presented (level>1 in PRESENT, level≥1 in WAIT).
  - A push that coalesces is never dropped, even when full.
- Not defined: every valid push is stored in order; no cancellation.

## Test plan
- Reset, then `btn2_deb` pulse, with `frame_tick` already given and `cmd_ready`=1 → `cmd_valid` after 2 edges with `cmd_dir`=1; handshake follows; `fifo_level` returns to 0.
- MAX_PER_FRAME=1, five pulses with no `frame_tick`, DEPTH=4 → `fifo_level`=4, one `overflow` pulse, `drop_cnt`=1, `cmd_valid` stays 0.
- Then 3 `frame_tick`s spaced 800 cycles apart with `cmd_ready`=1 → exactly 3 handshakes, one per frame, in push order; `fifo_level`=1.
- `cmd_ready`=0 for 50 cycles during PRESENT while pushes arrive → `cmd_valid` and `cmd_dir` are stable throughout; same-edge push and pop keeps the level constant.
- With `BTN_CMD_COALESCE_EN`: in WAIT with credits=0, push dir 0 then dir 1 → `fifo_level` goes 1 then 0 and no command is ever issued. Without the macro, the same stimulus gives `fifo_level`=2 and issues 0 then 1.
- `reset` on the handshake edge → all outputs 0 after the edge; `drop_cnt`=0.

Source files
------------

// File: rtl/btn_cmd_sched.sv
// Debounced-button command scheduler: queues left/right commands and releases them
// over valid/ready, at most MAX_PER_FRAME per frame. Optional macro: BTN_CMD_COALESCE_EN.
module btn_cmd_sched #(
    parameter int DEPTH         = 4,
    parameter int MAX_PER_FRAME = 1
) (
    input  logic                     vgaclk,
    input  logic                     reset,
    input  logic                     btn1_deb,
    input  logic                     btn2_deb,
    input  logic                     frame_tick,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic                     cmd_dir,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [2:0]    MAX_CRED = 3'(MAX_PER_FRAME);

    typedef enum logic {
        WAIT    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [2:0]      credits_q, credits_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_dir_q, cmd_dir_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic push_req;
    logic push_dir;
    logic pop;
    logic coalesce;
    logic store;
    logic drop;
`ifdef BTN_CMD_COALESCE_EN
    logic tail_dir;
`endif

    // Next-state computation for FIFO, credits, FSM and status outputs
    always_comb begin
        push_req = btn1_deb ^ btn2_deb;
        push_dir = btn2_deb;
        pop      = (state_q == PRESENT) && cmd_ready;
        coalesce = 1'b0;
`ifdef BTN_CMD_COALESCE_EN
        tail_dir = mem_q[wr_ptr_q - AW'(1)];
        // The presented head is off-limits as a cancellation target
        coalesce = push_req && (tail_dir != push_dir) &&
                   (level_q > ((state_q == PRESENT) ? LW'(1) : LW'(0)));
`endif
        store = push_req && !coalesce && ((level_q != DEPTH_L) || pop);
        drop  = push_req && !coalesce && (level_q == DEPTH_L) && !pop;

        mem_d = mem_q;
        if (store) begin
            mem_d[wr_ptr_q] = push_dir;
        end else begin
            mem_d = mem_q;
        end

        if (store) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else if (coalesce) begin
            wr_ptr_d = wr_ptr_q - AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        level_d = level_q + LW'(store) - LW'(pop) - LW'(coalesce);

        if (frame_tick) begin
            credits_d = MAX_CRED - 3'(pop);
        end else if (pop) begin
            credits_d = credits_q - 3'd1;
        end else begin
            credits_d = credits_q;
        end

        overflow_d = drop;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_dir_d   = cmd_dir_q;
        case (state_q)
            WAIT: begin
                // A sole entry being cancelled this edge must not be presented
                if ((level_q != LW'(0)) && (credits_q != 3'd0) &&
                    !(coalesce && (level_q == LW'(1)))) begin
                    state_d     = PRESENT;
                    cmd_valid_d = 1'b1;
                    cmd_dir_d   = mem_q[rd_ptr_q];
                end else begin
                    state_d     = WAIT;
                end
            end
            PRESENT: begin
                if (cmd_ready) begin
                    state_d     = WAIT;
                    cmd_valid_d = 1'b0;
                end else begin
                    state_d     = PRESENT;
                end
            end
            default: begin
                state_d     = WAIT;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            state_q     <= WAIT;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            credits_q   <= 3'd0;
            cmd_valid_q <= 1'b0;
            cmd_dir_q   <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            credits_q   <= credits_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_dir_q   <= cmd_dir_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_dir    = cmd_dir_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_btn_cmd_sched.sv
// Scoreboard bench for btn_cmd_sched (default DEPTH=4, MAX_PER_FRAME=1).
module tb_btn_cmd_sched;

    logic       vgaclk = 1'b0;
    logic       reset;
    logic       btn1_deb;
    logic       btn2_deb;
    logic       frame_tick;
    logic       cmd_ready;
    logic       cmd_valid;
    logic       cmd_dir;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;
    bit sb_q[$];
    bit exp_dir;

    btn_cmd_sched #(.DEPTH(4), .MAX_PER_FRAME(1)) dut (
        .vgaclk     (vgaclk),
        .reset      (reset),
        .btn1_deb   (btn1_deb),
        .btn2_deb   (btn2_deb),
        .frame_tick (frame_tick),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 vgaclk = ~vgaclk;

    // Handshake monitor: every accepted command must match the oldest expected push
    always @(posedge vgaclk) begin
        if (reset) begin
            sb_q.delete();
        end else if (cmd_valid && cmd_ready) begin
            hs_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL hs_unexpected: got dir=%0d, required no command", cmd_dir);
            end else begin
                exp_dir = sb_q.pop_front();
                if (cmd_dir !== exp_dir) begin
                    errors++;
                    $display("FAIL hs_dir: got %0d, required %0d", cmd_dir, exp_dir);
                end
            end
        end
    end

    task automatic step();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (cmd_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %0d, required 0", cmd_valid); end
        checks++; if (cmd_dir !== 1'b0)     begin errors++; $display("FAIL rst_dir: got %0d, required 0", cmd_dir); end
        checks++; if (fifo_level !== 3'd0)  begin errors++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_overflow: got %0d, required 0", overflow); end
        checks++; if (drop_cnt !== 8'd0)    begin errors++; $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int hs0;
        cmd_ready = 1'b1;
        tick();
        hs0 = hs_count;
        btn2_deb = 1'b1;
        sb_q.push_back(1'b1);
        step();
        btn2_deb = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL basic_level1: got %0d, required 1", fifo_level); end
        checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL basic_latency: got valid=%0d, required 0", cmd_valid); end
        step();
        checks++; if (cmd_valid !== 1'b1)  begin errors++; $display("FAIL basic_valid: got %0d, required 1", cmd_valid); end
        checks++; if (cmd_dir !== 1'b1)    begin errors++; $display("FAIL basic_dir: got %0d, required 1", cmd_dir); end
        step();
        checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL basic_drop_valid: got %0d, required 0", cmd_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL basic_level0: got %0d, required 0", fifo_level); end
        checks++; if (hs_count - hs0 != 1) begin errors++; $display("FAIL basic_hs: got %0d, required 1", hs_count - hs0); end
    endtask

    task automatic test_overflow();
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn1_deb = 1'b1;
            if (i < 4) sb_q.push_back(1'b0);
            step();
            btn1_deb = 1'b0;
            checks++;
            if (overflow !== (i == 4)) begin
                errors++; $display("FAIL ovf_pulse%0d: got %0d, required %0d", i, overflow, (i == 4));
            end
            step();
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear%0d: got %0d, required 0", i, overflow); end
        end
        repeat (5) step();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d, required 4", fifo_level); end
        checks++; if (drop_cnt !== 8'd1)   begin errors++; $display("FAIL ovf_drop_cnt: got %0d, required 1", drop_cnt); end
        checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL ovf_valid: got %0d, required 0", cmd_valid); end
    endtask

    task automatic test_frames();
        int hs0;
        cmd_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            hs0 = hs_count;
            tick();
            repeat (799) step();
            checks++;
            if (hs_count - hs0 != 1) begin
                errors++; $display("FAIL frame%0d_hs: got %0d, required 1", f, hs_count - hs0);
            end
        end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL frames_level: got %0d, required 1", fifo_level); end
        checks++; if (sb_q.size() != 1)    begin errors++; $display("FAIL frames_sb: got %0d, required 1", sb_q.size()); end
    endtask

    task automatic test_stall();
        int bad;
        cmd_ready = 1'b0;
        tick();
        step();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0d, required 1", cmd_valid); end
        checks++; if (cmd_dir !== 1'b0)   begin errors++; $display("FAIL stall_dir: got %0d, required 0", cmd_dir); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            btn1_deb = (i % 5 == 4) && (i < 15);
            if (btn1_deb) sb_q.push_back(1'b0);
            step();
            btn1_deb = 1'b0;
            if (cmd_valid !== 1'b1 || cmd_dir !== 1'b0) bad++;
        end
        checks++; if (bad != 0)            begin errors++; $display("FAIL stall_stable: got %0d unstable cycles, required 0", bad); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL stall_level: got %0d, required 4", fifo_level); end
        btn1_deb  = 1'b1;
        cmd_ready = 1'b1;
        sb_q.push_back(1'b0);
        step();
        btn1_deb  = 1'b0;
        cmd_ready = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL pushpop_level: got %0d, required 4", fifo_level); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL pushpop_ovf: got %0d, required 0", overflow); end
        checks++; if (drop_cnt !== 8'd1)   begin errors++; $display("FAIL pushpop_drop: got %0d, required 1", drop_cnt); end
        checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL pushpop_valid: got %0d, required 0", cmd_valid); end
    endtask

    task automatic test_coalesce();
        int hs0;
        int exp_hs;
        int exp_lvl;
        do_reset();
        cmd_ready = 1'b0;
`ifdef BTN_CMD_COALESCE_EN
        exp_hs  = 0;
        exp_lvl = 0;
`else
        exp_hs  = 2;
        exp_lvl = 2;
        sb_q.push_back(1'b0);
        sb_q.push_back(1'b1);
`endif
        btn1_deb = 1'b1;
        step();
        btn1_deb = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL coal_level1: got %0d, required 1", fifo_level); end
        btn2_deb = 1'b1;
        step();
        btn2_deb = 1'b0;
        checks++; if (fifo_level !== 3'(exp_lvl)) begin errors++; $display("FAIL coal_level2: got %0d, required %0d", fifo_level, exp_lvl); end
        repeat (5) step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL coal_nocredit: got %0d, required 0", cmd_valid); end
        hs0 = hs_count;
        cmd_ready = 1'b1;
        tick();
        repeat (5) step();
        tick();
        repeat (5) step();
        cmd_ready = 1'b0;
        checks++; if (hs_count - hs0 != exp_hs) begin errors++; $display("FAIL coal_hs: got %0d, required %0d", hs_count - hs0, exp_hs); end
        checks++; if (fifo_level !== 3'd0)      begin errors++; $display("FAIL coal_level_end: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_reset_handshake();
        int hs0;
        do_reset();
        cmd_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            btn2_deb = 1'b1;
            if (i < 4) sb_q.push_back(1'b1);
            step();
            btn2_deb = 1'b0;
            step();
        end
        checks++; if (drop_cnt !== 8'd1)  begin errors++; $display("FAIL rh_pre_drop: got %0d, required 1", drop_cnt); end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rh_pre_valid: got %0d, required 1", cmd_valid); end
        hs0 = hs_count;
        cmd_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL rh_valid: got %0d, required 0", cmd_valid); end
        checks++; if (cmd_dir !== 1'b0)    begin errors++; $display("FAIL rh_dir: got %0d, required 0", cmd_dir); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rh_level: got %0d, required 0", fifo_level); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL rh_overflow: got %0d, required 0", overflow); end
        checks++; if (drop_cnt !== 8'd0)   begin errors++; $display("FAIL rh_drop_cnt: got %0d, required 0", drop_cnt); end
        tick();
        repeat (4) step();
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL rh_after_valid: got %0d, required 0", cmd_valid); end
        checks++; if (hs_count != hs0)     begin errors++; $display("FAIL rh_after_hs: got %0d, required 0", hs_count - hs0); end
    endtask

    initial begin
        reset      = 1'b1;
        btn1_deb   = 1'b0;
        btn2_deb   = 1'b0;
        frame_tick = 1'b0;
        cmd_ready  = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_frames();
        test_stall();
        test_coalesce();
        test_reset_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
